// File: rtl/dot_product_engine_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_engine_pkg
//   Shared definitions for the dot-product engine:
//     - dp_state_e   : engine FSM encoding (also driven onto the state port)
//     - clog2        : ceiling log2 used to size the adder-tree growth bits
//     - prod_width   : width of one signed lane product
//     - tree_width   : width of the full-precision sum of all lane products
//     - DEF_*        : default lane/accumulator/length sizes of the engine
// -----------------------------------------------------------------------------
package dot_product_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } dp_state_e;

   localparam int DEF_DATA_W_IN  = 8;
   localparam int DEF_DATA_W_OUT = 32;
   localparam int DEF_PARA_DEG   = 4;
   localparam int DEF_BITS_LEN   = 6;

   // Returns 0 for n<=1, so a single-lane tree adds no growth bits.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int prod_width(input int din_w);
      return 2 * din_w;
   endfunction

   function automatic int tree_width(input int din_w, input int lanes);
      return 2 * din_w + clog2(lanes);
   endfunction

endpackage

// File: rtl/dot_product_engine_adder_tree.sv
// -----------------------------------------------------------------------------
// dp_adder_tree
//   Combinational signed reduction of N packed terms of IN_W bits each.
//   Every term is sign-extended to OUT_W before summing, so with
//   OUT_W = IN_W + clog2(N) the sum is exact.
// Ports
//   terms : N*IN_W packed signed terms, term i = terms[i*IN_W +: IN_W]
//   sum   : OUT_W signed sum of all terms
// -----------------------------------------------------------------------------
module dp_adder_tree
   import dot_product_engine_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int N     = 4,
   parameter int OUT_W = IN_W + clog2(N)
) (
   input  logic [N*IN_W-1:0]        terms,
   output logic signed [OUT_W-1:0]  sum
);

   always_comb begin
      logic signed [IN_W-1:0] term;
      term = '0;
      sum  = '0;
      for (int i = 0; i < N; i++) begin
         term = terms[i*IN_W +: IN_W];
         sum  = sum + OUT_W'(term);
      end
   end

endmodule

// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
//   Multi-lane signed dot-product engine. Each accepted beat multiplies
//   Para_Deg lane pairs, the products are reduced by dp_adder_tree and added
//   into a wrap-around accumulator. An operation covers num_beats+1 beats and
//   may be seeded with old_output.
// Ports
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   start, num_beats,
//   load_old_output,
//   old_output              : operation request, sampled when start is accepted
//   in_valid / in_ready     : beat handshake for data0/data1 (ready only in ACCUM)
//   data0, data1            : Para_Deg packed signed lanes
//   result / result_valid /
//   result_ready            : final accumulator, held until consumed
//   overflow                : sticky signed overflow of the accumulator adds
//   busy, state             : status (state: IDLE=0 ACCUM=1 DRAIN=2 DONE=3)
// -----------------------------------------------------------------------------
module dot_product_engine
   import dot_product_engine_pkg::*;
#(
   parameter int Data_Width_In  = DEF_DATA_W_IN,
   parameter int Data_Width_Out = DEF_DATA_W_OUT,
   parameter int Para_Deg       = DEF_PARA_DEG,
   parameter int bits_Len       = DEF_BITS_LEN
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [bits_Len-1:0]               num_beats,
   input  logic                              load_old_output,
   input  logic [Data_Width_Out-1:0]         old_output,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [Para_Deg*Data_Width_In-1:0] data0,
   input  logic [Para_Deg*Data_Width_In-1:0] data1,
   output logic [Data_Width_Out-1:0]         result,
   output logic                              result_valid,
   input  logic                              result_ready,
   output logic                              overflow,
   output logic                              busy,
   output logic [1:0]                        state
);

   localparam int PW = prod_width(Data_Width_In);
   localparam int TW = tree_width(Data_Width_In, Para_Deg);
   localparam int WW = (TW > Data_Width_Out) ? TW : Data_Width_Out;

   dp_state_e                          state_q, state_nx;
   logic                               start_acc;
   logic                               beat_xfer;
   logic [bits_Len-1:0]                cnt_q;

   logic [Para_Deg*PW-1:0]             prod_p1;
   logic                               vld_p1;
   logic signed [TW-1:0]               tree_sum_p1;
   logic signed [Data_Width_Out-1:0]   acc_q, acc_add_p1, acc_sum_p1;

   function automatic logic signed [PW-1:0] mul_lane(
      input logic signed [Data_Width_In-1:0] a,
      input logic signed [Data_Width_In-1:0] b);
      return PW'(a) * PW'(b);
   endfunction

   // Sign-extend or truncate the tree sum to accumulator width (wrap-around).
   function automatic logic signed [Data_Width_Out-1:0] fit_acc(
      input logic signed [TW-1:0] s);
      logic signed [WW-1:0] w;
      w = WW'(s);
      return w[Data_Width_Out-1:0];
   endfunction

   function automatic logic add_ovf(
      input logic signed [Data_Width_Out-1:0] a,
      input logic signed [Data_Width_Out-1:0] b,
      input logic signed [Data_Width_Out-1:0] s);
      return (a[Data_Width_Out-1] == b[Data_Width_Out-1]) &&
             (s[Data_Width_Out-1] != a[Data_Width_Out-1]);
   endfunction

   assign in_ready     = (state_q == ST_ACCUM);
   assign beat_xfer    = in_valid && in_ready;
   assign result_valid = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE);
   assign state        = state_q;
   assign result       = acc_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_nx;
   end

   always_comb begin
      state_nx  = state_q;
      start_acc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nx  = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat_xfer && (cnt_q == '0)) state_nx = ST_DRAIN;
         end
         // Stage 2 retires in the cycle stage 1 is valid, so an empty
         // stage 1 means the accumulator is final.
         ST_DRAIN: begin
            if (!vld_p1) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (result_ready) begin
               if (start) begin
                  start_acc = 1'b1;
                  state_nx  = ST_ACCUM;
               end else begin
                  state_nx  = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // ---- stage 1: lane products ----
   always_ff @(posedge clk) begin
      if (beat_xfer) begin
         for (int i = 0; i < Para_Deg; i++) begin
            prod_p1[i*PW +: PW] <= mul_lane(data0[i*Data_Width_In +: Data_Width_In],
                                            data1[i*Data_Width_In +: Data_Width_In]);
         end
      end
   end

   // ---- stage 2: adder tree and accumulate ----
   dp_adder_tree #(
      .IN_W  (PW),
      .N     (Para_Deg),
      .OUT_W (TW)
   ) u_tree (
      .terms (prod_p1),
      .sum   (tree_sum_p1)
   );

   assign acc_add_p1 = fit_acc(tree_sum_p1);
   assign acc_sum_p1 = acc_q + acc_add_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         vld_p1   <= 1'b0;
         acc_q    <= '0;
         overflow <= 1'b0;
      end else begin
         vld_p1 <= beat_xfer;
         if (start_acc) begin
            cnt_q    <= num_beats;
            acc_q    <= load_old_output ? old_output : '0;
            overflow <= 1'b0;
         end else begin
            if (beat_xfer) cnt_q <= cnt_q - 1'b1;
            if (vld_p1) begin
               acc_q <= acc_sum_p1;
               if (add_ovf(acc_q, acc_add_p1, acc_sum_p1)) overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dot_product_engine.sv
// -----------------------------------------------------------------------------
// tb_dot_product_engine
//   Directed bench for dot_product_engine (4 lanes x 8 bit, 32-bit result).
//   Expected results are pushed into a scoreboard when an operation is issued;
//   a monitor pops and compares whenever a result is handed over.
// -----------------------------------------------------------------------------
module tb_dot_product_engine;

   logic        clk = 1'b0;
   logic        reset, start, load_old_output, in_valid, result_ready;
   logic [5:0]  num_beats;
   logic [31:0] old_output, data0, data1;
   logic        in_ready, result_valid, overflow, busy;
   logic [31:0] result;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q_res[$];
   logic        q_ovf[$];

   dot_product_engine #(
      .Data_Width_In  (8),
      .Data_Width_Out (32),
      .Para_Deg       (4),
      .bits_Len       (6)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .num_beats       (num_beats),
      .load_old_output (load_old_output),
      .old_output      (old_output),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .data0           (data0),
      .data1           (data1),
      .result          (result),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .overflow        (overflow),
      .busy            (busy),
      .state           (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] r, input logic o);
      q_res.push_back(r);
      q_ovf.push_back(o);
   endtask

   task automatic start_op(input logic [5:0] nb, input logic ld, input logic [31:0] seed);
      start = 1'b1; num_beats = nb; load_old_output = ld; old_output = seed;
      tick;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d0, input logic [31:0] d1);
      in_valid = 1'b1; data0 = d0; data1 = d1;
      tick;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int max_cycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!result_valid && n < max_cycles);
      checks++;
      if (!result_valid) begin
         failures++;
         $display("FAIL result_valid_timeout actual=0 required=1 after %0d cycles", n);
      end
   endtask

   task automatic do_op(input logic [5:0] nb, input logic ld, input logic [31:0] seed,
                        input logic [31:0] d0, input logic [31:0] d1, input int beats);
      start_op(nb, ld, seed);
      for (int i = 0; i < beats; i++) send_beat(d0, d1);
      wait_valid(20);
      tick;
   endtask

   // Monitor: a result is consumed on any cycle with result_valid && result_ready.
   always @(negedge clk) begin
      if (!reset && result_valid && result_ready) begin
         if (q_res.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=0x%08h required=none", result);
         end else begin
            chk("sb_result", result, q_res.pop_front());
            chk("sb_overflow", {31'b0, overflow}, {31'b0, q_ovf.pop_front()});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; load_old_output = 1'b0; in_valid = 1'b0;
      result_ready = 1'b1; num_beats = '0; old_output = '0; data0 = '0; data1 = '0;
      repeat (2) tick;
      @(negedge clk);
      chk("por_state", state, 2'd0);
      chk("por_busy", busy, 1'b0);
      chk("por_in_ready", in_ready, 1'b0);
      chk("por_result_valid", result_valid, 1'b0);
      reset = 1'b0;
      tick;

      // Test 1: reset in the middle of ACCUM aborts the operation
      start_op(6'd3, 1'b1, 32'h1234_5678);
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      chk("mid_state_accum", state, 2'd1);
      reset = 1'b1;
      repeat (2) tick;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_state", state, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_result_valid", result_valid, 1'b0);
      chk("rst_result", result, 32'd0);
      chk("rst_overflow", overflow, 1'b0);
      tick;

      // Test 2: single beat, with in_valid ignored while IDLE beforehand
      in_valid = 1'b1; data0 = pk(50, 50, 50, 50); data1 = pk(50, 50, 50, 50);
      repeat (2) tick;
      in_valid = 1'b0;
      chk("idle_in_ready", in_ready, 1'b0);
      start_op(6'd0, 1'b0, 32'd0);
      push_exp(32'd70, 1'b0);
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      @(negedge clk); chk("lat_t1_valid", result_valid, 1'b0);
      @(negedge clk); chk("lat_t2_valid", result_valid, 1'b0);
      @(negedge clk); chk("lat_t3_valid", result_valid, 1'b1);
      chk("lat_t3_state", state, 2'd3);
      chk("lat_t3_result", result, 32'd70);
      tick;

      // Test 3: signed extremes
      push_exp(32'd131072, 1'b0);
      do_op(6'd1, 1'b0, 32'd0, pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 2);
      push_exp(32'hFFFF_0200, 1'b0);
      do_op(6'd0, 1'b0, 32'd0, pk(127, 127, 127, 127), pk(-128, -128, -128, -128), 1);

      // Test 4: seed causing signed overflow, then overflow cleared on next start
      push_exp(32'h8000_0036, 1'b1);
      do_op(6'd0, 1'b1, 32'h7FFF_FFF0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1);
      start_op(6'd0, 1'b0, 32'd0);
      push_exp(32'd70, 1'b0);
      @(negedge clk);
      chk("ovf_cleared_on_start", overflow, 1'b0);
      tick;
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      wait_valid(20);
      tick;

      // Test 5a: 4 beats with bubbles (in_valid 1,0,0,1,...); garbage data in bubbles
      start_op(6'd3, 1'b0, 32'd0);
      push_exp(32'd64636, 1'b0);
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      data0 = pk(99, 99, 99, 99); repeat (2) tick;
      send_beat(pk(-1, -1, -1, -1), pk(10, 20, 30, 40));
      data0 = pk(99, 99, 99, 99); repeat (2) tick;
      send_beat(pk(100, -100, 50, -50), pk(2, 1, 2, 1));
      data0 = pk(99, 99, 99, 99); repeat (2) tick;
      result_ready = 1'b0;
      send_beat(pk(127, 127, 127, 127), pk(127, 127, 127, 127));
      // Test 5b: backpressure holds the result
      wait_valid(20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_result", result, 32'd64636);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_valid", result_valid, 1'b1);
      end
      @(posedge clk); #1;
      result_ready = 1'b1;
      @(negedge clk);
      tick;

      // Same data without bubbles
      start_op(6'd3, 1'b0, 32'd0);
      push_exp(32'd64636, 1'b0);
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      send_beat(pk(-1, -1, -1, -1), pk(10, 20, 30, 40));
      send_beat(pk(100, -100, 50, -50), pk(2, 1, 2, 1));
      send_beat(pk(127, 127, 127, 127), pk(127, 127, 127, 127));
      wait_valid(20);
      tick;

      // Test 6: back-to-back start in DONE, then start ignored during ACCUM
      start_op(6'd0, 1'b0, 32'd0);
      push_exp(32'd70, 1'b0);
      send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
      wait_valid(20);
      start = 1'b1; num_beats = 6'd1; load_old_output = 1'b0; old_output = 32'd0;
      tick;
      start = 1'b0;
      push_exp(32'd131072, 1'b0);
      chk("b2b_state", state, 2'd1);
      chk("b2b_in_ready", in_ready, 1'b1);
      start = 1'b1; num_beats = 6'd0; load_old_output = 1'b1; old_output = 32'd1000;
      send_beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128));
      start = 1'b0;
      chk("accum_start_ignored", state, 2'd1);
      send_beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128));
      wait_valid(20);
      tick;

      // Maximum length: 64 beats, counter must not end early
      push_exp(32'd256, 1'b0);
      do_op(6'd63, 1'b0, 32'd0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 64);

      repeat (3) tick;
      chk("scoreboard_empty", q_res.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
